lookup_table: RTL
=================

Name: lookup_table

Overview:
- Table memory answering the credit block's read-request interface: it accepts rd_addr/rd_read and returns rd_data/rd_valid after a fixed pipeline latency.
- A host write port loads entries. A per-entry valid bitmap marks entries written since reset or clear.
- Reads of unwritten entries return MISS_VALUE with rd_hit=0.
- Sits directly downstream of the credit stage's rd_* port and feeds its result FIFO.

Parameters:
- LATENCY, 2, cycles from accepted rd_read to rd_valid; legal range 1..8, elaboration error otherwise.
- MISS_VALUE, 16'hDEAD, rd_data returned for a read of an invalid entry.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- reset_p  in  1  asynchronous active-high reset.
- rd_addr  in  8  read address, sampled when rd_read=1.
- rd_read  in  1  read request, one per cycle max, no backpressure.
- rd_data  out  16  read result, valid only while rd_valid=1.
- rd_valid  out  1  result strobe, single-cycle per request.
- rd_hit  out  1  1 = entry valid, 0 = miss (rd_data=MISS_VALUE); qualified by rd_valid.
- wr_addr  in  8  host write address.
- wr_data  in  16  host write data.
- wr_en  in  1  host write strobe.
- tbl_clear  in  1  one-cycle pulse: invalidate all 256 entries.

Behaviour:
- Reset (async assert, synchronous-safe deassert by system): rd_valid=0, rd_hit=0, rd_data=0, all pipeline stage valids=0, valid bitmap all 0. RAM contents are not reset.
- Storage: 256x16 RAM plus a 256-bit valid register.
- Write: wr_en at edge N updates mem[wr_addr] and sets valid[wr_addr]=1, both visible to reads sampled from cycle N+1 onward.
- Read: rd_read=1 in cycle N gives rd_valid=1 in cycle N+LATENCY, with rd_data/rd_hit from table state before edge N's updates. Read-first: a same-cycle write or clear is not seen.
- Throughput is one read per cycle. Back-to-back reads produce back-to-back rd_valid in the same order. There is no reordering and no drop.
- Pipeline: stage 0 registers the lookup (data, hit, valid). Stages 1..LATENCY-1 are a pure delay line. At LATENCY=1, stage 0 drives the outputs directly.
- Miss: if valid[addr]=0, then rd_data=MISS_VALUE and rd_hit=0. The stale RAM word is never exposed.
- tbl_clear at edge N sets all valid bits to 0. Reads already in the pipeline keep the results they captured.
- wr_en and tbl_clear in the same cycle: all entries cleared except wr_addr, which becomes valid with wr_data.
- rd_data/rd_hit hold their last value when rd_valid=0; bench must not check them then.
- Reset mid-operation: in-flight reads are discarded and no rd_valid is produced for them. Upstream must also be reset, since credits are not returned.
- X on rd_addr while rd_read=0 has no effect.

Decomposition:
- Package lookup_pkg: ADDR_W=8, DATA_W=16, TBL_DEPTH=256, default MISS_VALUE constant, typedef lookup_rsp_t {valid, hit, data[15:0]}.
- Sub-module lookup_pipe: parameterised LATENCY-1 stage delay line of lookup_rsp_t with async reset of the valid bits; instanced once.
- RAM, valid bitmap and stage-0 lookup stay in lookup_table.

Test Plan:
- After reset, rd_read addr 8'h05 at cycle 10 (LATENCY=2) -> rd_valid=1 at cycle 12, rd_hit=0, rd_data=16'hDEAD.
- wr_en addr 8'h05 data 16'h1234, then read addr 8'h05 next cycle -> rd_hit=1, rd_data=16'h1234 two cycles later.
- Same-cycle wr_en addr 8'h07 data 16'hBEEF and rd_read addr 8'h07 (entry previously 16'h0001, valid) -> response 16'h0001. Read in the following cycle -> 16'hBEEF.
- Fill addr 0..255 with data=addr*3, then 256 back-to-back reads -> 256 consecutive rd_valid, in order, all hit, data=addr*3, no gaps.
- tbl_clear concurrent with wr_en addr 8'h10 data 16'h0F0F -> later reads: addr 8'h10 gives hit, 16'h0F0F; addr 8'h11 gives miss, 16'hDEAD.
- Assert reset_p for 1 cycle with 2 reads in flight (LATENCY=4) -> rd_valid stays 0 for the next 4 cycles and all subsequent reads miss.

Source files
------------

// File: rtl/lookup_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lookup_pkg
// Purpose  : Shared widths, default miss word and the response record that
//            travels down the lookup_table read pipeline.
// Contents : ADDR_W, DATA_W, TBL_DEPTH, MISS_VALUE_DEFAULT, lookup_rsp_t
// Revision : 1.0  initial release
// ============================================================================
package lookup_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int TBL_DEPTH = 256;

  localparam logic [DATA_W-1:0] MISS_VALUE_DEFAULT = 16'hDEAD;

  // One read response in flight: strobe, hit flag and the returned word.
  typedef struct packed {
    logic              valid;
    logic              hit;
    logic [DATA_W-1:0] data;
  } lookup_rsp_t;

endpackage : lookup_pkg
`default_nettype wire

// File: rtl/lookup_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lookup_pipe
// Purpose  : STAGES-deep delay line for lookup responses. With STAGES=0 the
//            input is passed straight through.
// Ports    : clk    in   clock
//            rst    in   asynchronous active-high reset
//            i_rsp  in   response entering the delay line
//            o_rsp  out  response leaving the delay line
// Revision : 1.0  initial release
// ============================================================================
module lookup_pipe
  import lookup_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  lookup_rsp_t i_rsp,
  output lookup_rsp_t o_rsp
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_rsp = i_rsp;
    end else begin : g_delay
      lookup_rsp_t r_stage [STAGES];

      // The valid bit always shifts; hit/data only advance with a real
      // response so the outputs hold their last value across idle cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            r_stage[i] <= '0;
          end
        end else begin
          r_stage[0].valid <= i_rsp.valid;
          if (i_rsp.valid) begin
            r_stage[0].hit  <= i_rsp.hit;
            r_stage[0].data <= i_rsp.data;
          end
          for (int i = 1; i < STAGES; i++) begin
            r_stage[i].valid <= r_stage[i-1].valid;
            if (r_stage[i-1].valid) begin
              r_stage[i].hit  <= r_stage[i-1].hit;
              r_stage[i].data <= r_stage[i-1].data;
            end
          end
        end
      end

      assign o_rsp = r_stage[STAGES-1];
    end
  endgenerate

endmodule : lookup_pipe
`default_nettype wire

// File: rtl/lookup_table.sv
`default_nettype none
// ============================================================================
// Module   : lookup_table
// Purpose  : 256x16 lookup table with a per-entry valid bitmap. Reads return
//            the stored word (hit) or MISS_VALUE (miss) LATENCY cycles after
//            the request; host writes load entries, tbl_clear invalidates all.
// Ports    : aclk      in   clock
//            reset_p   in   asynchronous active-high reset
//            rd_addr   in   read address (sampled when rd_read=1)
//            rd_read   in   read request, at most one per cycle
//            rd_data   out  read result, qualified by rd_valid
//            rd_valid  out  single-cycle result strobe
//            rd_hit    out  1 = entry valid, 0 = miss
//            wr_addr   in   host write address
//            wr_data   in   host write data
//            wr_en     in   host write strobe
//            tbl_clear in   one-cycle pulse invalidating every entry
// Revision : 1.0  initial release
// ============================================================================
module lookup_table
  import lookup_pkg::*;
#(
  parameter int                LATENCY    = 2,
  parameter logic [DATA_W-1:0] MISS_VALUE = MISS_VALUE_DEFAULT
) (
  input  logic              aclk,
  input  logic              reset_p,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_read,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              tbl_clear
);

  generate
    if (LATENCY < 1 || LATENCY > 8) begin : g_latency_check
      $error("lookup_table: LATENCY must be in 1..8");
    end
  endgenerate

  logic [DATA_W-1:0]    r_mem [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] r_valid_map;
  lookup_rsp_t          r_stage0;
  lookup_rsp_t          w_out;

  // RAM contents deliberately have no reset; the valid bitmap guards them.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Clear first, then the write: a concurrent write survives the clear.
  always_ff @(posedge aclk or posedge reset_p) begin
    if (reset_p) begin
      r_valid_map <= '0;
    end else begin
      if (tbl_clear) begin
        r_valid_map <= '0;
      end
      if (wr_en) begin
        r_valid_map[wr_addr] <= 1'b1;
      end
    end
  end

  // Stage 0 samples pre-edge table state, so a same-cycle write or clear
  // is not observed (read-first). A miss never exposes the stale RAM word.
  always_ff @(posedge aclk or posedge reset_p) begin
    if (reset_p) begin
      r_stage0 <= '0;
    end else begin
      r_stage0.valid <= rd_read;
      if (rd_read) begin
        r_stage0.hit  <= r_valid_map[rd_addr];
        r_stage0.data <= r_valid_map[rd_addr] ? r_mem[rd_addr] : MISS_VALUE;
      end
    end
  end

  lookup_pipe #(
    .STAGES (LATENCY - 1)
  ) u_pipe (
    .clk   (aclk),
    .rst   (reset_p),
    .i_rsp (r_stage0),
    .o_rsp (w_out)
  );

  assign rd_valid = w_out.valid;
  assign rd_hit   = w_out.hit;
  assign rd_data  = w_out.data;

endmodule : lookup_table
`default_nettype wire
